// File: rtl/snax_gemmx_csr_manager.sv
// CSR request front-end for the GEMMX streamer/accelerator shell.
// Keeps shadow config registers and offers a committed copy to the accelerator over valid/ready.
module snax_gemmx_csr_manager #(
    parameter int unsigned RegRWCount   = 10,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned RegAddrWidth = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [RegAddrWidth-1:0]            csr_req_addr_i,
    input  logic [RegDataWidth-1:0]            csr_req_data_i,
    input  logic                               csr_req_write_i,
    input  logic                               csr_req_valid_i,
    output logic                               csr_req_ready_o,
    output logic [RegDataWidth-1:0]            csr_rsp_data_o,
    output logic                               csr_rsp_valid_o,
    input  logic                               csr_rsp_ready_i,
    output logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_o,
    output logic                               csr_reg_set_valid_o,
    input  logic                               csr_reg_set_ready_i,
    input  logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_i
);
    localparam int unsigned LaunchAddr = RegRWCount + RegROCount;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e                           r_state;
    logic                             r_rsp_valid;
    logic [RegDataWidth-1:0]          r_rsp_data;

    logic [RegRWCount*RegDataWidth-1:0] w_shadow_flat;
    logic                             w_is_launch;
    logic                             w_req_ready;
    logic                             w_accept;
    logic                             w_wr_accept;
    logic                             w_rd_accept;
    logic                             w_launch_accept;
    logic [RegDataWidth-1:0]          w_rd_data;

    assign w_is_launch     = csr_req_write_i && (csr_req_addr_i == RegAddrWidth'(LaunchAddr));
    assign w_accept        = csr_req_valid_i && w_req_ready;
    assign w_wr_accept     = w_accept && csr_req_write_i;
    assign w_rd_accept     = w_accept && !csr_req_write_i;
    assign w_launch_accept = w_accept && w_is_launch;

    // Launch ready uses the registered state, so it stays low through the handshake cycle.
    always_comb begin
        if (csr_req_write_i) begin
            w_req_ready = w_is_launch ? (r_state == ST_IDLE) : 1'b1;
        end else begin
            w_req_ready = !r_rsp_valid || csr_rsp_ready_i;
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < int'(RegRWCount); i++) begin
            if (csr_req_addr_i == RegAddrWidth'(i)) begin
                w_rd_data = w_shadow_flat[i*RegDataWidth +: RegDataWidth];
            end
        end
        for (int i = 0; i < int'(RegROCount); i++) begin
            if (csr_req_addr_i == RegAddrWidth'(int'(RegRWCount) + i)) begin
                w_rd_data = csr_reg_ro_set_i[i*RegDataWidth +: RegDataWidth];
            end
        end
        if (csr_req_addr_i == RegAddrWidth'(LaunchAddr)) begin
            w_rd_data = RegDataWidth'(r_state == ST_PENDING);
        end
    end

    // One shadow/committed register pair per RW address.
    for (genvar gi = 0; gi < int'(RegRWCount); gi++) begin : g_reg
        logic [RegDataWidth-1:0] r_shadow;
        logic [RegDataWidth-1:0] r_bank;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_shadow <= '0;
                r_bank   <= '0;
            end else begin
                if (w_wr_accept && (csr_req_addr_i == RegAddrWidth'(gi))) begin
                    r_shadow <= csr_req_data_i;
                end
                if (w_launch_accept) begin
                    r_bank <= r_shadow;
                end
            end
        end

        assign w_shadow_flat[gi*RegDataWidth +: RegDataWidth] = r_shadow;
        assign csr_reg_set_o[gi*RegDataWidth +: RegDataWidth] = r_bank;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch_accept) r_state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (csr_reg_set_ready_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Single-entry response register; a read in the consume cycle refills it.
            if (w_rd_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rd_data;
            end else if (csr_rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign csr_req_ready_o     = w_req_ready;
    assign csr_rsp_valid_o     = r_rsp_valid;
    assign csr_rsp_data_o      = r_rsp_data;
    assign csr_reg_set_valid_o = (r_state == ST_PENDING);

endmodule

// File: tb/tb_snax_gemmx_csr_manager.sv
// Scoreboard bench for snax_gemmx_csr_manager: a cycle-level reference model predicts
// responses and committed banks; a separate monitor pops and compares them.
module tb_snax_gemmx_csr_manager;
    localparam int RW = 10;
    localparam int RO = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LA = RW + RO;

    typedef logic [RW*DW-1:0] wide_t;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [AW-1:0]     csr_req_addr_i;
    logic [DW-1:0]     csr_req_data_i;
    logic              csr_req_write_i;
    logic              csr_req_valid_i;
    logic              csr_req_ready_o;
    logic [DW-1:0]     csr_rsp_data_o;
    logic              csr_rsp_valid_o;
    logic              csr_rsp_ready_i;
    logic [RW*DW-1:0]  csr_reg_set_o;
    logic              csr_reg_set_valid_o;
    logic              csr_reg_set_ready_i;
    logic [RO*DW-1:0]  csr_reg_ro_set_i;
    logic [DW-1:0]     ro_words [RO];

    assign csr_reg_ro_set_i = {ro_words[1], ro_words[0]};

    snax_gemmx_csr_manager #(
        .RegRWCount(RW), .RegROCount(RO), .RegDataWidth(DW), .RegAddrWidth(AW)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .csr_req_addr_i      (csr_req_addr_i),
        .csr_req_data_i      (csr_req_data_i),
        .csr_req_write_i     (csr_req_write_i),
        .csr_req_valid_i     (csr_req_valid_i),
        .csr_req_ready_o     (csr_req_ready_o),
        .csr_rsp_data_o      (csr_rsp_data_o),
        .csr_rsp_valid_o     (csr_rsp_valid_o),
        .csr_rsp_ready_i     (csr_rsp_ready_i),
        .csr_reg_set_o       (csr_reg_set_o),
        .csr_reg_set_valid_o (csr_reg_set_valid_o),
        .csr_reg_set_ready_i (csr_reg_set_ready_i),
        .csr_reg_ro_set_i    (csr_reg_ro_set_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] m_shadow [RW];
    logic [DW-1:0] m_bank   [RW];
    bit            m_pending;
    bit            m_rsp_valid;
    logic [DW-1:0] rsp_q [$];
    wide_t         set_q [$];
    bit            acc_flag;
    bit            m_launch, m_ready, m_hs, m_cons;
    bit            rand_hs = 1'b0;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wide_t pack(input logic [DW-1:0] regs [RW]);
        wide_t r;
        for (int i = 0; i < RW; i++) r[i*DW +: DW] = regs[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] read_model(input logic [AW-1:0] a);
        if (a < RW) return m_shadow[a];
        if (a < LA) return ro_words[a - RW];
        if (a == LA) return DW'(m_pending);
        return '0;
    endfunction

    // Model: evaluated mid-cycle, predicts what the next rising edge does.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < RW; i++) begin
                m_shadow[i] = '0;
                m_bank[i]   = '0;
            end
            m_pending   = 1'b0;
            m_rsp_valid = 1'b0;
            acc_flag    = 1'b0;
            rsp_q.delete();
            set_q.delete();
        end else begin
            check("set_valid", wide_t'(csr_reg_set_valid_o), wide_t'(m_pending));
            check("rsp_valid", wide_t'(csr_rsp_valid_o), wide_t'(m_rsp_valid));
            if (m_pending) check("set_stable", csr_reg_set_o, pack(m_bank));

            m_launch = csr_req_write_i && (csr_req_addr_i == AW'(LA));
            if (csr_req_write_i) m_ready = m_launch ? !m_pending : 1'b1;
            else                 m_ready = !m_rsp_valid || csr_rsp_ready_i;
            if (csr_req_valid_i) check("req_ready", wide_t'(csr_req_ready_o), wide_t'(m_ready));
            acc_flag = csr_req_valid_i && m_ready;
            m_hs     = m_pending && csr_reg_set_ready_i;
            m_cons   = m_rsp_valid && csr_rsp_ready_i;

            if (acc_flag && !csr_req_write_i) begin
                rsp_q.push_back(read_model(csr_req_addr_i));
                m_rsp_valid = 1'b1;
            end else if (m_cons) begin
                m_rsp_valid = 1'b0;
            end
            if (m_hs) m_pending = 1'b0;
            if (acc_flag && m_launch) begin
                m_bank = m_shadow;
                set_q.push_back(pack(m_shadow));
                m_pending = 1'b1;
            end
            if (acc_flag && csr_req_write_i && csr_req_addr_i < RW)
                m_shadow[csr_req_addr_i] = csr_req_data_i;
        end
    end

    // Monitor: compares each consumed response and each accepted bank.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (csr_rsp_valid_o && csr_rsp_ready_i) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rsp_unexpected: got %0h expected no response", csr_rsp_data_o);
                end else begin
                    check("rsp_data", wide_t'(csr_rsp_data_o), wide_t'(rsp_q.pop_front()));
                end
            end
            if (csr_reg_set_valid_o && csr_reg_set_ready_i) begin
                if (set_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL set_unexpected: got %0h expected no bank", csr_reg_set_o);
                end else begin
                    check("set_bank", csr_reg_set_o, set_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk_i) begin
        if (rand_hs) begin
            #1;
            csr_reg_set_ready_i = ($urandom_range(0, 2) == 0);
            csr_rsp_ready_i     = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        csr_req_write_i = wr;
        csr_req_addr_i  = a;
        csr_req_data_i  = d;
        csr_req_valid_i = 1'b1;
        for (int c = 0; ; c++) begin
            @(posedge clk_i); #1;
            if (acc_flag) break;
            if (c == 60) begin
                n_cmp++; n_err++;
                $display("FAIL req_timeout: got no acceptance expected accept addr %0d", a);
                break;
            end
        end
        csr_req_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        csr_req_addr_i = '0; csr_req_data_i = '0; csr_req_write_i = 1'b0; csr_req_valid_i = 1'b0;
        csr_rsp_ready_i = 1'b1; csr_reg_set_ready_i = 1'b1;
        ro_words[0] = '0; ro_words[1] = '0;

        // Reset state
        csr_req_valid_i = 1'b1; csr_req_write_i = 1'b1; csr_req_addr_i = '0; csr_req_data_i = 32'h55;
        #2;
        check("rst_set_valid", wide_t'(csr_reg_set_valid_o), '0);
        check("rst_rsp_valid", wide_t'(csr_rsp_valid_o), '0);
        check("rst_rsp_data", wide_t'(csr_rsp_data_o), '0);
        check("rst_set_o", csr_reg_set_o, '0);
        check("rst_req_ready", wide_t'(csr_req_ready_o), wide_t'(1));
        repeat (2) @(posedge clk_i);
        #1; csr_req_valid_i = 1'b0; rst_ni = 1'b1;

        // Basic launch with accelerator always ready
        do_req(1, 0, 2); do_req(1, 1, 2); do_req(1, 2, 2); do_req(1, 3, 0);
        do_req(1, LA, 32'hffff_ffff);
        repeat (3) @(posedge clk_i);
        #1;

        // Accelerator stalls; shadow update must not leak into the pending bank
        csr_reg_set_ready_i = 1'b0;
        do_req(1, LA, 0);
        do_req(1, 0, 7);
        check("set0_held", wide_t'(csr_reg_set_o[DW-1:0]), wide_t'(2));
        fork
            do_req(1, LA, 0);
            begin
                repeat (4) @(posedge clk_i);
                #1; csr_reg_set_ready_i = 1'b1;
            end
        join
        repeat (3) @(posedge clk_i);
        #1;

        // RO read with a stalled response consumer
        csr_rsp_ready_i = 1'b0;
        ro_words[0] = 32'h1234;
        do_req(0, 10, 0);
        check("ro_read_data", wide_t'(csr_rsp_data_o), wide_t'(32'h1234));
        ro_words[0] = 32'hdead_beef;
        fork
            do_req(0, 11, 0);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk_i); #1;
                    check("rsp_held", wide_t'(csr_rsp_data_o), wide_t'(32'h1234));
                end
                csr_rsp_ready_i = 1'b1;
            end
        join
        repeat (2) @(posedge clk_i);
        #1;

        // Launch-status read while pending, out-of-range accesses
        csr_reg_set_ready_i = 1'b0;
        do_req(1, LA, 0);
        do_req(0, LA, 0);
        check("launch_read", wide_t'(csr_rsp_data_o), wide_t'(1));
        do_req(1, 20, 5);
        do_req(0, 20, 0);
        check("oob_read", wide_t'(csr_rsp_data_o), '0);
        for (int a = 0; a < 4; a++) do_req(0, AW'(a), 0);

        // Asynchronous reset while pending
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        check("arst_set_valid", wide_t'(csr_reg_set_valid_o), '0);
        check("arst_set_o", csr_reg_set_o, '0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        csr_reg_set_ready_i = 1'b1;
        do_req(0, 0, 0);
        check("rd0_after_rst", wide_t'(csr_rsp_data_o), '0);

        // Randomized traffic with random back-pressure on both outputs
        rand_hs = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) a = AW'(LA);
            ro_words[0] = $urandom;
            ro_words[1] = $urandom;
            do_req(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i); #1;
            end
        end
        rand_hs = 1'b0;
        @(posedge clk_i); #2;
        csr_rsp_ready_i = 1'b1;
        csr_reg_set_ready_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        check("rsp_q_drained", wide_t'(rsp_q.size()), '0);
        check("set_q_drained", wide_t'(set_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
